// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT with stage gaps and downstream stalls.
// Optional FFT_SEQ_INVERSE_EN adds an `inverse` input that selects conjugate twiddles.
module fft_stage_sequencer #(
    parameter int unsigned N         = 16,
    parameter int unsigned STAGE_GAP = 4,
    localparam int unsigned L        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic         inverse,
`endif
    output logic         busy,
    output logic         done,
    output logic         bfly_valid,
    input  logic         bfly_ready,
    output logic [L-1:0] stage,
    output logic [L-1:0] addr_a,
    output logic [L-1:0] addr_b,
    output logic [L-1:0] tw_addr
);

    localparam int unsigned CW       = L - 1;
    localparam int unsigned GW       = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int unsigned GAP_LAST = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;
    localparam int unsigned C_LAST   = N / 2 - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [L-1:0]    s_q, s_d;
    logic [CW-1:0]   c_q, c_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            last_q, last_d;
    logic            busy_d, done_d, valid_d;
    logic [L-1:0]    stage_d, addr_a_d, addr_b_d;
    logic            issue;
    logic            hs;
    logic [L-1:0]    c_ext, mask_n, a_next, b_next, k_sel;
`ifdef FFT_SEQ_INVERSE_EN
    logic            inv_q, inv_d;
`endif

    // Twiddle exponent: low s bits of the operand index, scaled to the N-point ROM.
    function automatic logic [L-1:0] twiddle_idx(input logic [L-1:0] s, input logic [L-1:0] x);
        logic [L-1:0] mask;
        mask = (L'(1) << s) - L'(1);
        return (x & mask) << (L'(L - 1) - s);
    endfunction

    // Index of the next butterfly: insert a zero bit at position s of the counter.
    always_comb begin
        c_ext  = L'(c_q);
        mask_n = (L'(1) << s_q) - L'(1);
        a_next = ((c_ext & ~mask_n) << 1) | (c_ext & mask_n);
        b_next = a_next | (L'(1) << s_q);
    end

    assign hs = bfly_valid & bfly_ready;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        gap_d    = gap_q;
        last_d   = last_q;
        busy_d   = busy;
        done_d   = 1'b0;
        valid_d  = bfly_valid;
        stage_d  = stage;
        addr_a_d = addr_a;
        addr_b_d = addr_b;
        issue    = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
        inv_d    = inv_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    issue   = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
                    inv_d   = inverse;
`endif
                end
            end
            S_RUN: begin
                if (hs && last_q && (stage == L'(L - 1))) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (hs && last_q && (STAGE_GAP != 0)) begin
                    state_d = S_GAP;
                    valid_d = 1'b0;
                    gap_d   = '0;
                end else if (!bfly_valid || bfly_ready) begin
                    issue = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) begin
                    state_d = S_RUN;
                    issue   = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                s_d     = '0;
                c_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Present the butterfly held in the counters and advance them.
        if (issue) begin
            valid_d  = 1'b1;
            stage_d  = s_q;
            addr_a_d = a_next;
            addr_b_d = b_next;
            last_d   = (c_q == CW'(C_LAST));
            if (c_q == CW'(C_LAST)) begin
                c_d = '0;
                s_d = s_q + L'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    // ROM address: next twiddle when issuing, presented twiddle while stalled.
    always_comb begin
        k_sel = '0;
        if (issue) begin
            k_sel = twiddle_idx(s_q, c_ext);
        end else if (bfly_valid && !bfly_ready) begin
            k_sel = twiddle_idx(stage, addr_a);
        end
`ifdef FFT_SEQ_INVERSE_EN
        tw_addr = inv_q ? (L'(0) - k_sel) : k_sel;
`else
        tw_addr = k_sel;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            c_q        <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bfly_valid <= 1'b0;
            stage      <= '0;
            addr_a     <= '0;
            addr_b     <= '0;
`ifdef FFT_SEQ_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            busy       <= busy_d;
            done       <= done_d;
            bfly_valid <= valid_d;
            stage      <= stage_d;
            addr_a     <= addr_a_d;
            addr_b     <= addr_b_d;
`ifdef FFT_SEQ_INVERSE_EN
            inv_q      <= inv_d;
`endif
        end
    end

endmodule
